cellrv32_npu_instr_packer: RTL and testbench



---
 rtl/cellrv32_npu_instr_packer_pkg.sv | 52 +++++
 rtl/cellrv32_npu_instr_packer_fifo.sv | 72 +++++++
 rtl/cellrv32_npu_instr_packer.sv | 120 ++++++++++++
 tb/tb_cellrv32_npu_instr_packer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cellrv32_npu_instr_packer_pkg.sv
// -----------------------------------------------------------------------------
// cellrv32_npu_instr_packer_pkg
// NPU instruction bit format shared by the writer (packer) and the consumer
// (decoder) sides.
//   Layout (INSTRUCTION_WIDTH = 80):
//     opcode [7:0], calc_len [39:8], acc_addr [55:40], buff_addr [79:56]
//   bits_to_instruction / instruction_to_bits are exact inverses.
// -----------------------------------------------------------------------------
package cellrv32_npu_instr_packer_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 80;
  localparam int unsigned INSTR_BUS_WORDS   = 3;

  // Staging word select on the CPU bus.
  typedef enum logic [1:0] {
    ADDR_WORD0  = 2'd0,
    ADDR_WORD1  = 2'd1,
    ADDR_COMMIT = 2'd2,
    ADDR_RSVD   = 2'd3
  } bus_addr_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] calc_len;
    logic [15:0] acc_addr;
    logic [23:0] buff_addr;
  } instruction_t;

  function automatic instruction_t bits_to_instruction(
    input logic [INSTRUCTION_WIDTH-1:0] bits
  );
    instruction_t instr;
    instr.opcode    = bits[7:0];
    instr.calc_len  = bits[39:8];
    instr.acc_addr  = bits[55:40];
    instr.buff_addr = bits[79:56];
    return instr;
  endfunction

  function automatic logic [INSTRUCTION_WIDTH-1:0] instruction_to_bits(
    input instruction_t instr
  );
    logic [INSTRUCTION_WIDTH-1:0] bits;
    bits        = '0;
    bits[7:0]   = instr.opcode;
    bits[39:8]  = instr.calc_len;
    bits[55:40] = instr.acc_addr;
    bits[79:56] = instr.buff_addr;
    return bits;
  endfunction

endpackage

// File: rtl/cellrv32_npu_instr_packer_fifo.sv
// -----------------------------------------------------------------------------
// cellrv32_npu_instr_fifo
// Generic synchronous first-word-fall-through FIFO.
//   clk_i, rst_i (sync, active-high), clear_i (sync flush, priority over
//   push/pop), push_i/data_i (ignored while full), pop_i (ignored while
//   empty), data_o (head, 0 while empty), full_o, empty_o, level_o.
// Pointers carry one wrap bit above the index bits.
// -----------------------------------------------------------------------------
module cellrv32_npu_instr_fifo #(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  always_comb begin
    w_full  = ((r_wr_ptr ^ r_rd_ptr) == FULL_XOR);
    w_empty = (r_wr_ptr == r_rd_ptr);
    // Fullness is judged on the pre-edge state, so a push into a full FIFO
    // is refused even if a pop frees a slot on the same edge.
    w_push  = push_i & ~w_full;
    w_pop   = pop_i & ~w_empty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i && !clear_i) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end
  end

  // Unwritten storage is never exposed: the head reads as zero while empty.
  assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/cellrv32_npu_instr_packer.sv
// -----------------------------------------------------------------------------
// cellrv32_npu_instr_packer
// Packs 32-bit CPU bus writes into 80-bit NPU instructions and queues them
// for the NPU control unit over a valid/ready handshake.
//   clk_i, rst_i      : clock / synchronous active-high reset
//   wr_en_i           : bus write strobe
//   wr_addr_i         : 0 -> stage[31:0], 1 -> stage[63:32],
//                       2 -> commit {wr_data_i[15:0], stage}, 3 -> ignored
//   wr_data_i         : bus write data
//   clear_i           : flush staging, FIFO and overflow flag
//   instr_o, valid_o  : head instruction (FWFT) and its valid
//   ready_i           : consumer accepts head
//   full_o, empty_o, level_o : FIFO status
//   overflow_o        : sticky, a commit was dropped while full
//   issued_cnt_o      : pop counter, only with CELLRV32_NPU_INSTR_COUNT_EN
// -----------------------------------------------------------------------------
module cellrv32_npu_instr_packer
  import cellrv32_npu_instr_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [1:0]                    wr_addr_i,
  input  logic [31:0]                   wr_data_i,
  input  logic                          clear_i,
  output logic [INSTRUCTION_WIDTH-1:0]  instr_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [LEVEL_WIDTH-1:0]        level_o,
`ifdef CELLRV32_NPU_INSTR_COUNT_EN
  output logic [31:0]                   issued_cnt_o,
`endif
  output logic                          overflow_o
);

  logic [63:0] r_stage;
  logic        r_overflow;

  bus_addr_e                    w_addr;
  logic                         w_commit;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_empty;
  logic [INSTRUCTION_WIDTH-1:0] w_commit_bits;
  logic [INSTRUCTION_WIDTH-1:0] w_head;
  logic [LEVEL_WIDTH-1:0]       w_level;
  logic                         w_unused_hi;

  always_comb begin
    w_addr        = bus_addr_e'(wr_addr_i);
    w_commit      = wr_en_i && (w_addr == ADDR_COMMIT);
    w_pop         = ~w_empty & ready_i;
    w_commit_bits = {wr_data_i[15:0], r_stage};
  end

  assign w_unused_hi = &{1'b0, wr_data_i[31:16]};

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_stage <= '0;
    end else if (wr_en_i) begin
      case (w_addr)
        ADDR_WORD0: r_stage[31:0]  <= wr_data_i;
        ADDR_WORD1: r_stage[63:32] <= wr_data_i;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_overflow <= 1'b0;
    end else if (w_commit && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  cellrv32_npu_instr_fifo #(
    .WIDTH (INSTRUCTION_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (w_commit),
    .data_i  (w_commit_bits),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

`ifdef CELLRV32_NPU_INSTR_COUNT_EN
  logic [31:0] r_issued_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_issued_cnt <= '0;
    end else if (w_pop) begin
      r_issued_cnt <= r_issued_cnt + 32'd1;
    end
  end

  assign issued_cnt_o = r_issued_cnt;
`endif

  assign instr_o    = w_head;
  assign valid_o    = ~w_empty;
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign level_o    = w_level;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_cellrv32_npu_instr_packer.sv
module tb_cellrv32_npu_instr_packer;
  import cellrv32_npu_instr_packer_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        clear = 1'b0;
  logic        ready = 1'b0;
  logic [79:0] instr;
  logic        valid;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;
`ifdef CELLRV32_NPU_INSTR_COUNT_EN
  logic [31:0] issued_cnt;
`endif

  always #5 clk = ~clk;

  cellrv32_npu_instr_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .clear_i    (clear),
    .instr_o    (instr),
    .valid_o    (valid),
    .ready_i    (ready),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
`ifdef CELLRV32_NPU_INSTR_COUNT_EN
    .issued_cnt_o (issued_cnt),
`endif
    .overflow_o (overflow)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: a queue of committed instructions plus staging words.
  logic [79:0] mq[$];
  logic [63:0] m_stage = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_cnt = '0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check_eq("valid", 80'(valid), 80'(mq.size() != 0));
    check_eq("empty", 80'(empty), 80'(mq.size() == 0));
    check_eq("full", 80'(full), 80'(mq.size() == DEPTH));
    check_eq("level", 80'(level), 80'(mq.size()));
    check_eq("overflow", 80'(overflow), 80'(m_ovf));
    if (mq.size() != 0) check_eq("instr", instr, mq[0]);
`ifdef CELLRV32_NPU_INSTR_COUNT_EN
    check_eq("issued_cnt", 80'(issued_cnt), 80'(m_cnt));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d,
                     input logic rdy, input logic clr, input logic rs);
    logic was_full;
    logic do_pop;
    wr_en = we; wr_addr = a; wr_data = d; ready = rdy; clear = clr; rst = rs;
    @(posedge clk);
    if (rs || clr) begin
      mq.delete();
      m_stage = '0;
      m_ovf   = 1'b0;
      m_cnt   = '0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && rdy;
      if (do_pop) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (we) begin
        if (a == 2'd0) m_stage[31:0] = d;
        else if (a == 2'd1) m_stage[63:32] = d;
        else if (a == 2'd2) begin
          if (was_full) m_ovf = 1'b1;
          else mq.push_back({d[15:0], m_stage});
        end
      end
    end
    #1;
    check_model();
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 2'd0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic commit_op(input logic [7:0] op, input logic rdy);
    cyc(1'b1, 2'd0, {24'h0, op}, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);
  endtask

  instruction_t dec;

  initial begin
    // Reset
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_instr", instr, 80'h0);
    check_eq("rst_empty", 80'(empty), 80'd1);

    // Basic packing and field decode
    cyc(1'b1, 2'd0, 32'h11223344, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 32'h55667788, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 32'hDEADAABB, 1'b0, 1'b0, 1'b0);
    check_eq("t1_valid", 80'(valid), 80'd1);
    check_eq("t1_instr", instr, 80'hAABB_55667788_11223344);
    dec = bits_to_instruction(instr);
    check_eq("t1_opcode", 80'(dec.opcode), 80'h44);
    check_eq("t1_calc_len", 80'(dec.calc_len), 80'h88112233);
    check_eq("t1_acc_addr", 80'(dec.acc_addr), 80'h6677);
    check_eq("t1_buff_addr", 80'(dec.buff_addr), 80'hAABB55);
    check_eq("t1_roundtrip", instruction_to_bits(dec), 80'hAABB_55667788_11223344);
    cyc(1'b1, 2'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);  // address 3: no effect
    check_eq("t1_addr3", instr, 80'hAABB_55667788_11223344);
    drain();

    // Fill, overflow, ordered drain
    for (int i = 0; i < DEPTH; i++) commit_op(8'(i), 1'b0);
    check_eq("t2_full", 80'(full), 80'd1);
    check_eq("t2_level", 80'(level), 80'd8);
    commit_op(8'hEE, 1'b0);
    check_eq("t2_ovf", 80'(overflow), 80'd1);
    check_eq("t2_level9", 80'(level), 80'd8);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("t2_order", 80'(instr[7:0]), 80'(i));
      idle(1'b1);
    end
    check_eq("t2_empty", 80'(empty), 80'd1);

    // Level 3, simultaneous commit and pop
    for (int i = 0; i < 3; i++) commit_op(8'(8'h30 + i), 1'b0);
    commit_op(8'h33, 1'b1);
    check_eq("t3_level", 80'(level), 80'd3);
    check_eq("t3_head", 80'(instr[7:0]), 80'h31);
    drain();

    // Full, simultaneous commit and pop: commit dropped
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) commit_op(8'(8'h40 + i), 1'b0);
    commit_op(8'h4F, 1'b1);
    check_eq("t4_level", 80'(level), 80'd7);
    check_eq("t4_ovf", 80'(overflow), 80'd1);

    // Level 5 with overflow, clear with a commit
    idle(1'b1);
    idle(1'b1);
    check_eq("t5_level5", 80'(level), 80'd5);
    cyc(1'b1, 2'd2, 32'h0000BEEF, 1'b1, 1'b1, 1'b0);
    check_eq("t5_level", 80'(level), 80'd0);
    check_eq("t5_empty", 80'(empty), 80'd1);
    check_eq("t5_valid", 80'(valid), 80'd0);
    check_eq("t5_ovf", 80'(overflow), 80'd0);
    cyc(1'b1, 2'd2, 32'h00001234, 1'b0, 1'b0, 1'b0);
    check_eq("t5_low_zero", 80'(instr[63:0]), 80'h0);
    check_eq("t5_hi", 80'(instr[79:64]), 80'h1234);
    drain();

`ifdef CELLRV32_NPU_INSTR_COUNT_EN
    cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) commit_op(8'(i), 1'b1);
    drain();
    check_eq("cnt10", 80'(issued_cnt), 80'd10);
    commit_op(8'h77, 1'b0);
    @(negedge clk);
    dut.r_issued_cnt = 32'hFFFFFFFF;
    m_cnt = 32'hFFFFFFFF;
    #1;
    idle(1'b1);
    check_eq("cnt_wrap", 80'(issued_cnt), 80'd0);
`endif

    // Randomized traffic against the model
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        logic        rw;
        logic [1:0]  ra;
        logic [31:0] rd;
        logic        rr;
        logic        rc;
        logic        rs;
        rw = ($urandom_range(0, 3) != 0);
        ra = 2'($urandom_range(0, 3));
        rd = $urandom;
        rr = ($urandom_range(0, 5) < ph);
        rc = ($urandom_range(0, 99) == 0);
        rs = ($urandom_range(0, 199) == 0);
        cyc(rw, ra, rd, rr, rc, rs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
